axi_lite_cmd_master: RTL and testbench
======================================

# axi_lite_cmd_master

Synthesizable AXI4-Lite master that turns a single-outstanding command/response stream into AXI4-Lite read and write transactions. It sits directly upstream of the AXI-Lite slave register block, driving its s00_axi_* port. It gives the design's controllers (UART/debug bridges, init sequencers) the same regread/regwrite capability the simulation master model provides. It adds a response timeout and a sticky bus-fault flag.

## Interface
Parameters:
- C_M_AXI_DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- C_M_AXI_ADDR_WIDTH, 8, AXI byte-address width.
- C_TIMEOUT_CYCLES, 255, maximum wait cycles per transaction before abort; range 1 to 65535.

Ports (one clock; reset is synchronous and active-high):
- m00_axi_aclk  in  1  clock.
- m00_axi_areset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response produced by timeout.
- bus_fault  out  1  sticky; set by any timeout.
- m00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master directions and widths.

## Operation
- FSM states: IDLE, WR (AW and W phases), WR_B, RD_AR, RD_R, RSP.
- IDLE: cmd_ready = 1 unless bus_fault. On cmd_valid && cmd_ready, latch addr, wdata, wstrb and write.
  - Write: go to WR.
  - Read: go to RD_AR.
- WR: awvalid and wvalid asserted together.
  - Each valid drops independently on its own handshake, tracked by aw_done and w_done.
  - Both phases complete: go to WR_B.
  - AW before W, W before AW, and both in the same cycle are all legal.
- WR_B: bready = 1. On the bvalid handshake, capture bresp, set rsp_rdata = 0, go to RSP.
- RD_AR: arvalid = 1 until arready, then go to RD_R.
- RD_R: rready = 1. On the rvalid handshake, capture rdata and rresp, go to RSP.
- RSP: rsp_valid = 1; outputs are held stable until rsp_ready, then go to IDLE.
- awprot and arprot are tied to 3'b000.
- Any slave BRESP/RRESP value, including SLVERR/DECERR, is passed through unchanged.
- Timeout: a counter is cleared on command accept and increments every cycle in WR, WR_B, RD_AR and RD_R. When it equals C_TIMEOUT_CYCLES:
  - all AXI valids and readies drop;
  - rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0;
  - bus_fault is set; go to RSP.
- bus_fault holds cmd_ready at 0 until reset. Dropping valid on timeout is accepted only as hung-slave recovery.

## Timing
- Reset values: all AXI valids and readies 0; cmd_ready 0; rsp_valid 0; rsp_rdata 0; rsp_resp 0; rsp_timeout 0; bus_fault 0; state IDLE.
- cmd_ready rises the first cycle after reset deasserts.
- All outputs are registered.
- AXI valids assert the cycle after command accept.
- rsp_valid asserts the cycle after the final B or R handshake.
- Zero-wait slave (ready the same cycle as valid):
  - read: accept at N, AR handshake at N+1, R at N+2, rsp_valid at N+3;
  - write: AW and W at N+1, B at N+2, rsp_valid at N+3.
- Next command accept no earlier than the cycle after the rsp handshake.
- Exactly one transaction is outstanding.
- Reset asserted mid-transaction: all outputs return to reset values at the next edge and bus_fault clears. The slave is expected to be reset in the same cycle.
- Timeout fires on the cycle the counter equals C_TIMEOUT_CYCLES; no AXI handshake is accepted in that cycle.

## Structure
- Shared package axi_lite_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - FSM state encoding;
  - AXI_PROT_DEFAULT.
- One sub-module, axi_lite_timeout_ctr: clear, enable and expired signals, parameterised by C_TIMEOUT_CYCLES.

## Test plan
- Read, zero-wait slave: addr 0x04, slave returns 0x12345678 with OKAY -> rsp_valid at N+3, rsp_rdata = 0x12345678, rsp_resp = 0.
- Write with skewed handshakes: addr 0x08, data 0xDEADBEEF, wstrb 0xF; wready 3 cycles after awready -> single AW and single W handshake; read-back returns 0xDEADBEEF.
- Partial strobe: write 0xAABBCCDD with wstrb 4'b0011 over 0x00000000 -> read-back 0x0000CCDD.
- Error and backpressure: slave returns SLVERR on B; rsp_ready held low 5 cycles -> rsp_resp = 2'b10 stable, cmd_ready = 0 until the rsp handshake.
- Timeout: C_TIMEOUT_CYCLES = 16, arready never asserted -> arvalid drops after 16 cycles, rsp_timeout = 1, rsp_resp = 2'b10, bus_fault = 1, cmd_ready stays 0 until reset.
- Reset mid-write: assert reset while in WR_B -> next edge all outputs at reset values; after release a read of 0x00 completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants and command-master FSM encoding.
// Pure declarations: no latency, no flow control.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WR_B  = 3'd2,
        ST_RD_AR = 3'd3,
        ST_RD_R  = 3'd4,
        ST_RSP   = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Per-transaction wait counter: cleared on command accept, counts while enabled.
// expired_o is combinational and rises in the cycle before the count reaches the limit.
module axi_lite_timeout_ctr #(
    parameter int unsigned C_TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(C_TIMEOUT_CYCLES);
    localparam logic [15:0] LAST  = LIMIT - 16'd1;

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag one cycle early so the registered valids are already low when the count hits LIMIT.
    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding command/response to AXI4-Lite master; 3-cycle zero-wait round trip.
// Holds rsp stable until rsp_ready; a hung slave is aborted by timeout and latches bus_fault.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_TIMEOUT_CYCLES   = 255
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_areset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              bus_fault,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   wstrb_q;
    logic            awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic            cmd_ready_q, rsp_valid_q, rsp_timeout_q, bus_fault_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic [1:0]      rsp_resp_q;

    logic accept, tmo_en, tmo_expired, tmo_fire;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done, w_done;

    assign accept  = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign tmo_en  = (state_q == ST_WR) || (state_q == ST_WR_B) ||
                     (state_q == ST_RD_AR) || (state_q == ST_RD_R);
    assign aw_hs   = awvalid_q && m00_axi_awready;
    assign w_hs    = wvalid_q  && m00_axi_wready;
    assign b_hs    = bready_q  && m00_axi_bvalid;
    assign ar_hs   = arvalid_q && m00_axi_arready;
    assign r_hs    = rready_q  && m00_axi_rvalid;
    // In WR a phase is done once its valid has dropped or it handshakes this cycle.
    assign aw_done = !awvalid_q || aw_hs;
    assign w_done  = !wvalid_q  || w_hs;
    // A final B/R handshake landing on the expiry cycle completes normally.
    assign tmo_fire = tmo_expired && !b_hs && !r_hs;

    axi_lite_timeout_ctr #(
        .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i     (m00_axi_aclk),
        .rst_i     (m00_axi_areset),
        .clear_i   (accept),
        .enable_i  (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_OKAY;
            rsp_timeout_q <= 1'b0;
            bus_fault_q   <= 1'b0;
        end else if (tmo_fire) begin
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            bus_fault_q   <= 1'b1;
            state_q       <= ST_RSP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= !bus_fault_q;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        wdata_q     <= cmd_wdata;
                        wstrb_q     <= cmd_wstrb;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_RD_AR;
                        end
                    end
                end
                ST_WR: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (b_hs) begin
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= m00_axi_bresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RSP;
                    end
                end
                ST_RD_AR: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (r_hs) begin
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= m00_axi_rdata;
                        rsp_resp_q    <= m00_axi_rresp;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= !bus_fault_q;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign bus_fault       = bus_fault_q;
    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awprot  = AXI_PROT_DEFAULT;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = bready_q;
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arprot  = AXI_PROT_DEFAULT;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench: memory-backed AXI-Lite slave with programmable delays, reference memory model.
module tb_axi_lite_cmd_master;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout, bus_fault;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (8),
        .C_TIMEOUT_CYCLES   (16)
    ) dut (
        .m00_axi_aclk (clk), .m00_axi_areset (rst),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout), .bus_fault (bus_fault),
        .m00_axi_awaddr (awaddr), .m00_axi_awprot (awprot), .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready), .m00_axi_wdata (wdata), .m00_axi_wstrb (wstrb),
        .m00_axi_wvalid (wvalid), .m00_axi_wready (wready), .m00_axi_bresp (bresp),
        .m00_axi_bvalid (bvalid), .m00_axi_bready (bready), .m00_axi_araddr (araddr),
        .m00_axi_arprot (arprot), .m00_axi_arvalid (arvalid), .m00_axi_arready (arready),
        .m00_axi_rdata (rdata), .m00_axi_rresp (rresp), .m00_axi_rvalid (rvalid),
        .m00_axi_rready (rready)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] slv_mem [64];
    int          checks = 0, errors = 0, cyc = 0;
    int          acc_cyc = 0, first_cyc = 0;
    int          aw_hs_cnt = 0, w_hs_cnt = 0;
    int          d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
    int          hold_lo = 0;
    bit          rand_bp = 0, ar_block = 0;
    logic [1:0]  slv_resp = 2'b00;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [42:0] all_outs();
        return {awvalid, wvalid, bready, arvalid, rready, cmd_ready, rsp_valid,
                rsp_timeout, bus_fault, rsp_resp, rsp_rdata};
    endfunction

    // AXI-Lite slave: each channel waits its programmed delay after valid before asserting ready/valid.
    initial begin
        logic f_aw, f_w, f_b, f_ar, f_r, saw_rst, aw_have, w_have, ar_have;
        logic [7:0]  aw_a, ar_a, s_awaddr, s_araddr;
        logic [31:0] w_d, s_wdata;
        logic [3:0]  w_s, s_wstrb;
        int c_aw, c_w, c_b, c_ar, c_r;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0;
        rdata = 0; rresp = 0; rsp_ready = 0;
        aw_have = 0; w_have = 0; ar_have = 0; aw_a = 0; ar_a = 0; w_d = 0; w_s = 0;
        c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
        forever begin
            @(negedge clk);
            f_aw = awvalid && awready; f_w = wvalid && wready; f_b = bvalid && bready;
            f_ar = arvalid && arready; f_r = rvalid && rready;
            s_awaddr = awaddr; s_araddr = araddr; s_wdata = wdata; s_wstrb = wstrb;
            saw_rst = rst;
            @(posedge clk);
            #1;
            if (saw_rst) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_have = 0; w_have = 0; ar_have = 0;
                c_aw = 0; c_w = 0; c_b = 0; c_ar = 0; c_r = 0;
            end else begin
                if (f_aw) begin aw_have = 1; aw_a = s_awaddr; aw_hs_cnt++; end
                if (f_w)  begin w_have = 1; w_d = s_wdata; w_s = s_wstrb; w_hs_cnt++; end
                if ((f_aw || f_w) && aw_have && w_have)
                    for (int b = 0; b < 4; b++)
                        if (w_s[b]) slv_mem[aw_a[7:2]][8*b +: 8] = w_d[8*b +: 8];
                if (f_b) begin aw_have = 0; w_have = 0; bvalid = 0; c_b = 0; end
                if (f_ar) begin ar_have = 1; ar_a = s_araddr; end
                if (f_r) begin ar_have = 0; rvalid = 0; c_r = 0; end

                awready = 0;
                if (awvalid && !aw_have) begin
                    if (c_aw >= d_aw) begin awready = 1; c_aw = 0; end else c_aw++;
                end
                wready = 0;
                if (wvalid && !w_have) begin
                    if (c_w >= d_w) begin wready = 1; c_w = 0; end else c_w++;
                end
                if (aw_have && w_have && !bvalid) begin
                    if (c_b >= d_b) begin bvalid = 1; bresp = slv_resp; end else c_b++;
                end
                arready = 0;
                if (arvalid && !ar_have && !ar_block) begin
                    if (c_ar >= d_ar) begin arready = 1; c_ar = 0; end else c_ar++;
                end
                if (ar_have && !rvalid) begin
                    if (c_r >= d_r) begin
                        rvalid = 1; rdata = slv_mem[ar_a[7:2]]; rresp = slv_resp;
                    end else c_r++;
                end
            end
            if (hold_lo > 0) begin
                rsp_ready = 0;
                if (rsp_valid) hold_lo--;
            end else begin
                rsp_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Response monitor: pops the scoreboard on each rsp handshake, checks hold-stability otherwise.
    initial begin
        bit          held;
        logic [34:0] held_v;
        exp_t        e;
        held = 0; held_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
            end else if (rsp_valid) begin
                if (!held) first_cyc = cyc;
                check("cmd_ready_low_during_rsp", cmd_ready, 0);
                if (held) check("rsp_stable", {rsp_rdata, rsp_resp, rsp_timeout}, held_v);
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got rdata 0x%0h resp %0d with empty scoreboard",
                                 rsp_rdata, rsp_resp);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_resp", rsp_resp, e.resp);
                        check("rsp_timeout", rsp_timeout, e.tmo);
                    end
                    held = 0;
                end else begin
                    held = 1;
                    held_v = {rsp_rdata, rsp_resp, rsp_timeout};
                end
            end
        end
    end

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        d_aw = aw; d_w = w; d_b = b; d_ar = ar; d_r = r;
    endtask

    // Called at posedge+#1; returns at posedge+#1 of the cycle after accept.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [1:0] r, input bit tmo);
        int   n;
        exp_t e;
        slv_resp = r;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
        n = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 50) break;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept: cmd_ready not seen within %0d cycles", n);
        end else begin
            acc_cyc = cyc;
            if (tmo) begin
                e = '{rdata: 32'h0, resp: 2'b10, tmo: 1'b1};
            end else if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
                e = '{rdata: 32'h0, resp: r, tmo: 1'b0};
            end else begin
                e = '{rdata: ref_mem[a[7:2]], resp: r, tmo: 1'b0};
            end
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: response still pending after %0d cycles", nm, n);
            exp_q.delete();
        end
    endtask

    initial begin
        int n, nwr;
        logic wr;
        logic [1:0] r;
        rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        for (int i = 0; i < 64; i++) begin ref_mem[i] = 32'h0; slv_mem[i] = 32'h0; end
        ref_mem[1] = 32'h12345678; slv_mem[1] = 32'h12345678;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outs(), 43'h0);
        check("reset_prot", {awprot, arprot}, 6'h0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("cmd_ready_during_release", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_reset", cmd_ready, 1);
        @(posedge clk); #1;

        set_delays(0, 0, 0, 0, 0);
        issue(0, 8'h04, 32'h0, 4'h0, 2'b00, 0);
        wait_idle("zero_wait_read");
        check("rd_latency", first_cyc - acc_cyc, 3);

        issue(1, 8'h10, 32'h0BADF00D, 4'hF, 2'b00, 0);
        wait_idle("zero_wait_write");
        check("wr_latency", first_cyc - acc_cyc, 3);

        aw_hs_cnt = 0; w_hs_cnt = 0;
        set_delays(0, 3, 0, 0, 0);
        issue(1, 8'h08, 32'hDEADBEEF, 4'hF, 2'b00, 0);
        wait_idle("skew_write");
        check("skew_aw_count", aw_hs_cnt, 1);
        check("skew_w_count", w_hs_cnt, 1);
        set_delays(0, 0, 0, 0, 0);
        issue(0, 8'h08, 32'h0, 4'h0, 2'b00, 0);
        wait_idle("skew_readback");

        issue(1, 8'h00, 32'hAABBCCDD, 4'b0011, 2'b00, 0);
        wait_idle("partial_write");
        issue(0, 8'h00, 32'h0, 4'h0, 2'b00, 0);
        wait_idle("partial_readback");

        hold_lo = 5;
        issue(1, 8'h0C, 32'h55AA55AA, 4'hF, 2'b10, 0);
        wait_idle("slverr_backpressure");

        aw_hs_cnt = 0; w_hs_cnt = 0; nwr = 0;
        rand_bp = 1;
        for (int t = 0; t < 150; t++) begin
            set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            if (wr) nwr++;
            issue(wr, {6'($urandom_range(0, 63)), 2'b00}, $urandom, 4'($urandom_range(0, 15)), r, 0);
            wait_idle("random_txn");
        end
        check("random_aw_count", aw_hs_cnt, nwr);
        check("random_w_count", w_hs_cnt, nwr);
        rand_bp = 0;

        set_delays(0, 0, 8, 0, 0);
        issue(1, 8'h20, 32'hCAFEF00D, 4'hF, 2'b00, 0);
        n = 0;
        while (!bready && n < 30) begin @(negedge clk); n++; end
        check("reached_wr_b", bready, 1);
        @(posedge clk); #1; rst = 1; exp_q.delete();
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("reset_mid_write_outputs", all_outs(), 43'h0);
        @(negedge clk);
        check("cmd_ready_after_mid_reset", cmd_ready, 1);
        @(posedge clk); #1;
        set_delays(0, 0, 0, 0, 0);
        issue(0, 8'h00, 32'h0, 4'h0, 2'b00, 0);
        wait_idle("read_after_mid_reset");

        ar_block = 1;
        issue(0, 8'h10, 32'h0, 4'h0, 2'b00, 1);
        n = 1;
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            if (arvalid) n++;
        end
        check("timeout_arvalid_cycles", n - 1, 16);
        check("timeout_bus_fault", bus_fault, 1);
        check("timeout_arvalid_dropped", arvalid, 0);
        wait_idle("timeout_rsp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("fault_cmd_ready_held_low", cmd_ready, 0);
        end
        check("fault_sticky", bus_fault, 1);

        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0; ar_block = 0;
        @(negedge clk);
        check("fault_cleared_by_reset", all_outs(), 43'h0);
        @(posedge clk); #1;
        issue(0, 8'h04, 32'h0, 4'h0, 2'b00, 0);
        wait_idle("read_after_fault_reset");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
